// File: rtl/ili_fill_rect_pkg.sv
// rtl/ili_fill_rect_pkg.sv - shared constants, types and byte selector for the ILI9341 fill-rectangle generator
package ili_fill_rect_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int PANEL_H_RES = 240;
   localparam int PANEL_V_RES = 320;

   // Header positions 0..10; IDX_PIX marks the pixel phase
   localparam logic [3:0] IDX_PIX = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_FINISH
   } fill_state_e;

   typedef struct packed {
      logic [8:0]  x0;
      logic [8:0]  x1;
      logic [8:0]  y0;
      logic [8:0]  y1;
      logic [15:0] color;
   } st_fill_req;

   // Returns {dc, data} for a stream position; coordinates are zero-extended to 16 bits
   function automatic logic [8:0] fill_byte(input logic [3:0] idx, input logic lo,
                                            input st_fill_req req);
      logic [8:0] b;
      case (idx)
         4'd0:    b = {1'b0, CMD_CASET};
         4'd1:    b = {1'b1, 7'd0, req.x0[8]};
         4'd2:    b = {1'b1, req.x0[7:0]};
         4'd3:    b = {1'b1, 7'd0, req.x1[8]};
         4'd4:    b = {1'b1, req.x1[7:0]};
         4'd5:    b = {1'b0, CMD_PASET};
         4'd6:    b = {1'b1, 7'd0, req.y0[8]};
         4'd7:    b = {1'b1, req.y0[7:0]};
         4'd8:    b = {1'b1, 7'd0, req.y1[8]};
         4'd9:    b = {1'b1, req.y1[7:0]};
         4'd10:   b = {1'b0, CMD_RAMWR};
         default: b = lo ? {1'b1, req.color[7:0]} : {1'b1, req.color[15:8]};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ili_fill_rect_if.sv
// rtl/ili_fill_rect_if.sv - byte link toward the SPI byte engine (spi_ctrl)
interface ili_fill_rect_if;
   logic       o_send;
   logic [7:0] o_data;
   logic       o_dc;
   logic       o_cs;
   logic       i_byte_done;

   modport master (output o_send, output o_data, output o_dc, output o_cs, input i_byte_done);
   modport slave  (input o_send, input o_data, input o_dc, input o_cs, output i_byte_done);
endinterface

// File: rtl/ili_fill_rect_pix_counter.sv
// rtl/ili_fill_rect_pix_counter.sv - 17-bit load/decrement pixel counter with zero and last flags
module ili_fill_rect_pix_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [16:0] i_load_val,
   input  logic        i_dec,
   output logic        o_zero,
   output logic        o_last
);
   logic [16:0] cnt_q, cnt_d;

   // Saturates at zero so a stray decrement can never wrap to 0x1FFFF
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (i_dec && (cnt_q != 17'd0)) begin
         cnt_d = cnt_q - 17'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 17'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_zero = (cnt_q == 17'd0);
   assign o_last = (cnt_q == 17'd1);
endmodule

// File: rtl/ili_fill_rect.sv
// rtl/ili_fill_rect.sv - CASET/PASET/RAMWR header plus RGB565 pixel byte stream for one rectangle
module ili_fill_rect
   import ili_fill_rect_pkg::*;
#(
   parameter int H_RES = PANEL_H_RES,
   parameter int V_RES = PANEL_V_RES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [8:0]      i_x0,
   input  logic [8:0]      i_x1,
   input  logic [8:0]      i_y0,
   input  logic [8:0]      i_y1,
   input  logic [15:0]     i_color,
   input  logic            i_abort,
   ili_fill_rect_if.master spi,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_aborted,
   output logic            o_err
);
   fill_state_e state_q, state_d;
   st_fill_req  req_q, req_d;
   logic [3:0]  idx_q, idx_d;
   logic        lo_q, lo_d;
   logic        send_q, send_d;
   logic [7:0]  data_q, data_d;
   logic        dc_q, dc_d;
   logic        cs_q, cs_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic        err_q, err_d;

   logic        cnt_load, cnt_dec, cnt_zero, cnt_last;
   logic        in_range, pix_lo, last_byte;
   logic [8:0]  width, height;
   logic [16:0] area;

   assign in_range = (i_x0 <= i_x1) && ({1'b0, i_x1} < 10'(H_RES)) &&
                     (i_y0 <= i_y1) && ({1'b0, i_y1} < 10'(V_RES));
   assign width  = i_x1 - i_x0 + 9'd1;
   assign height = i_y1 - i_y0 + 9'd1;
   assign area   = 17'(width) * 17'(height);

   assign pix_lo    = (idx_q == IDX_PIX) && lo_q;
   assign last_byte = pix_lo && (cnt_last || cnt_zero);

   ili_fill_rect_pix_counter u_pix_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (cnt_load),
      .i_load_val (area),
      .i_dec      (cnt_dec),
      .o_zero     (cnt_zero),
      .o_last     (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      send_d    = 1'b0;
      data_d    = data_q;
      dc_d      = dc_q;
      cs_d      = cs_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      err_d     = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (in_range) begin
                  req_d    = '{x0: i_x0, x1: i_x1, y0: i_y0, y1: i_y1, color: i_color};
                  idx_d    = 4'd0;
                  lo_d     = 1'b0;
                  cnt_load = 1'b1;
                  send_d   = 1'b1;
                  cs_d     = 1'b0;
                  busy_d   = 1'b1;
                  state_d  = ST_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (spi.i_byte_done) begin
               cnt_dec = pix_lo;
               if (last_byte || i_abort) begin
                  done_d    = 1'b1;
                  aborted_d = !last_byte;
                  cs_d      = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = ST_FINISH;
               end else begin
                  send_d  = 1'b1;
                  state_d = ST_ISSUE;
                  if (idx_q != IDX_PIX) begin
                     idx_d = idx_q + 4'd1;
                     lo_d  = 1'b0;
                  end else begin
                     lo_d = ~lo_q;
                  end
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Byte and dc are registered together with the launch pulse and then held through WAIT
      if (send_d) begin
         {dc_d, data_d} = fill_byte(idx_d, lo_d, req_d);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         idx_q     <= 4'd0;
         lo_q      <= 1'b0;
         send_q    <= 1'b0;
         data_q    <= 8'h00;
         dc_q      <= 1'b0;
         cs_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         idx_q     <= idx_d;
         lo_q      <= lo_d;
         send_q    <= send_d;
         data_q    <= data_d;
         dc_q      <= dc_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         err_q     <= err_d;
      end
   end

   assign spi.o_send = send_q;
   assign spi.o_data = data_q;
   assign spi.o_dc   = dc_q;
   assign spi.o_cs   = cs_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_aborted  = aborted_q;
   assign o_err      = err_q;
endmodule

// File: doc/ili_fill_rect.md
# ili_fill_rect

Command/pixel stream generator for the ILI9341 path. After panel init, it takes one rectangle request (corners plus RGB565 colour) and emits the full byte sequence: CASET, 4 data bytes, PASET, 4 data bytes, RAMWR, then 2 bytes per pixel. Bytes go one at a time to the SPI byte engine (spi_ctrl/spi_shift) through the same send/done/data/dc/cs interface that send_command drives. It sits beside send_command, upstream of the SPI stage, and a top-level mux selects between the two.

## Interface
Parameters:
- H_RES, 240: panel width in pixels; x must be < H_RES.
- V_RES, 320: panel height in pixels; y must be < V_RES.

Ports:
- clk  in  1  divided system clock (same domain as spi_ctrl).
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle request strobe; sampled only in IDLE.
- i_x0, i_x1  in  9 each  column start/end, inclusive.
- i_y0, i_y1  in  9 each  row start/end, inclusive.
- i_color  in  16  RGB565 fill colour.
- i_abort  in  1  level; stop after the byte currently in flight.
- i_byte_done  in  1  one-cycle pulse from spi_ctrl: the current byte has been shifted out.
- o_send  out  1  one-cycle pulse that launches a byte.
- o_data  out  8  byte to send; held stable from o_send until i_byte_done.
- o_dc  out  1  0 = command byte, 1 = data byte; held with o_data.
- o_cs  out  1  panel chip select, active-low.
- o_busy  out  1  high from acceptance until o_done.
- o_done  out  1  one-cycle pulse at the end of a sequence, whether normal or aborted.
- o_aborted  out  1  qualifies o_done; high only in the o_done cycle when the sequence ended by abort.
- o_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE, on i_start:
  - Validate x0≤x1<H_RES and y0≤y1<V_RES.
  - If invalid: o_err pulses the next cycle and the block stays in IDLE. o_cs is not touched.
  - If valid: latch all inputs, load the pixel count N=(x1−x0+1)*(y1−y0+1) into a 17-bit counter (max 76800), clear the header index, go to ISSUE.
- ISSUE: o_send=1 for exactly one cycle, o_cs=0. o_data/o_dc are selected by position:
  - header idx 0: 0x2A, dc=0
  - idx 1–4: x0[15:8], x0[7:0], x1[15:8], x1[7:0], dc=1 (coordinates zero-extended to 16 bits)
  - idx 5: 0x2B, dc=0
  - idx 6–9: y0/y1 bytes in the same order, dc=1
  - idx 10: 0x2C, dc=0
  - pixel phase: color[15:8] then color[7:0], dc=1, alternating by a hi/lo toggle.
- WAIT: hold o_data/o_dc and ignore everything except i_byte_done. On i_byte_done:
  - Go to FINISH if this was the last pixel's low byte, or if i_abort is high.
  - Otherwise advance the index (lo byte decrements the pixel counter) and go to ISSUE.
- FINISH: o_done=1 for one cycle, o_cs=1, o_busy=0, then IDLE.
- i_start while busy: ignored, no error. i_byte_done outside WAIT: ignored.
- The counter decrements once per completed low byte and never wraps; when it reaches zero the next step is FINISH.
- Reset asserted at any point: all state and outputs return to reset values immediately. A partially sent byte is abandoned, and o_cs going high terminates the transfer at the panel.

## Timing
- Reset values: o_send=0, o_data=0x00, o_dc=0, o_cs=1, o_busy=0, o_done=0, o_aborted=0, o_err=0.
- i_start at cycle T (valid): o_busy=1, o_cs=0 and o_send=1 at T+1.
- i_byte_done at cycle T: the next o_send is at T+1. Minimum byte period is 2 cycles plus the SPI latency.
- The last i_byte_done at T gives o_done=1 and o_cs=1 at T+1, and o_busy=0 at T+1.
- An invalid i_start at T gives o_err=1 at T+1 only.
- All outputs are registered, with no combinational path from input to output.
- Total bytes per request = 11 + 2N.

## Structure
Add to pkg_ili9341:
- constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C
- localparams for 240/320
- enum typedef for the four states
- struct st_fill_req {x0,x1,y0,y1,color}

One natural sub-module is fill_pix_counter: a 17-bit load/decrement counter with a zero flag. The multiplier for N is computed once at acceptance.

## Test plan
- 1×1 at (0,0), colour 0xF800 → bytes 2A,00,00,00,00,2B,00,00,00,00,2C,F8,00; dc 0,1,1,1,1,0,1,1,1,1,0,1,1; o_done after the 13th i_byte_done; o_cs low throughout.
- Rect x 10..12, y 300..301, colour 0x07E0 → header bytes 2A,00,0A,00,0C,2B,01,2C,01,2D,2C, then 6 pixels = 12 bytes 07,E0 repeated; 23 bytes total.
- Full screen 0..239 × 0..319 → exactly 153611 o_send pulses, counter reaches 0 without wrap, one o_done.
- x1=240 or y0=5 with y1=4 → o_err pulse at T+1, no o_send, o_cs stays 1.
- i_abort during pixel 3 → the current byte completes, o_done with o_aborted=1 one cycle after its i_byte_done, no further o_send; a following request runs normally.
- rst low in mid-header while WAIT → o_cs=1, o_busy=0, o_send=0 asynchronously; after release a new i_start restarts from 0x2A.
